branch_cmp_seq: RTL and testbench

Parametrised, multi-cycle branch comparator for the rv32im core's execute stage. It takes two operands and a branch funct3 through a valid/ready handshake. It compares the operands CHUNK bits per cycle, starting at the MSB, and can finish early once the result is known. It returns eq, lt, taken and illegal through a second valid/ready handshake. It generalises the single-cycle signed/unsigned comparator to arbitrary width, full branch decode and slice-serial operation for area-constrained builds.

---
 rtl/branch_cmp_seq_pkg.sv | 41 ++++
 rtl/branch_cmp_seq_if.sv | 36 +++
 rtl/branch_slice_cmp.sv | 15 +
 rtl/branch_cmp_seq.sv | 157 +++++++++++++++
 tb/tb_branch_cmp_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_cmp_seq_pkg.sv
// branch_pkg: shared definitions for the slice-serial branch comparator.
//   - funct3 encodings for the RV32 conditional branches (also used by the
//     decoder and the execute-stage result mux)
//   - FSM state encoding of branch_cmp_seq
//   - helpers that decode funct3 into "illegal" and "taken"
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // 010 and 011 are not branch encodings.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic       eq,
                                        input logic       lt);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = ~eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = ~lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_cmp_seq_if.sv
// branch_cmp_seq_if: request/result bundle of the branch comparator.
//   Request : in_valid, in_ready, a, b, funct3
//   Result  : out_valid, out_ready, eq, lt, taken, illegal
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and its payload stable until that
// edge; the consumer may change ready freely; ready never depends on valid
// combinationally.
//
// master: the side issuing requests and consuming results (execute stage/tb).
// slave : the comparator.
interface branch_cmp_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [2:0]      funct3;
  logic            out_valid;
  logic            out_ready;
  logic            eq;
  logic            lt;
  logic            taken;
  logic            illegal;

  modport master (
    output in_valid, a, b, funct3, out_ready,
    input  in_ready, out_valid, eq, lt, taken, illegal
  );

  modport slave (
    input  in_valid, a, b, funct3, out_ready,
    output in_ready, out_valid, eq, lt, taken, illegal
  );
endinterface

// File: rtl/branch_slice_cmp.sv
// branch_slice_cmp: unsigned compare of one CHUNK-bit slice.
//   sa, sb : slice operands
//   ne     : sa != sb
//   lt     : sa <  sb (unsigned)
module branch_slice_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] sa,
  input  logic [CHUNK-1:0] sb,
  output logic             ne,
  output logic             lt
);
  assign ne = (sa != sb);
  assign lt = (sa < sb);
endmodule

// File: rtl/branch_cmp_seq.sv
// branch_cmp_seq: multi-cycle branch comparator, CHUNK bits per cycle from
// the MSB slice down, optionally stopping at the first differing slice.
//   clk, rst : clock, synchronous active-high reset
//   flush    : synchronous abort; returns to IDLE and drops any result
//   bus      : branch_cmp_seq_if slave (request a/b/funct3, result
//              eq/lt/taken/illegal, each with valid/ready)
//   state_o  : current FSM state (debug)
module branch_cmp_seq
  import branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CHUNK      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  branch_cmp_seq_if.slave  bus,
  output state_e           state_o
);

  localparam int NSLICE = XLEN / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((CHUNK < 1) || ((XLEN % CHUNK) != 0)) begin : g_bad_chunk
    $error("branch_cmp_seq: XLEN must be a multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2:0]        f3_q, f3_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              decided_q, decided_d;
  logic              cmp_lt_q, cmp_lt_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;
  logic              taken_q, taken_d;
  logic              illegal_q, illegal_d;

  // Slice selection: shift the current slice down to bit 0.
  logic [XLEN-1:0]   a_sh, b_sh;
  logic [CHUNK-1:0]  sa, sb;
  logic              s_ne, s_lt;

  assign a_sh = a_q >> (32'(idx_q) * CHUNK);
  assign b_sh = b_q >> (32'(idx_q) * CHUNK);
  assign sa   = a_sh[CHUNK-1:0];
  assign sb   = b_sh[CHUNK-1:0];

  branch_slice_cmp #(.CHUNK(CHUNK)) u_slice (
    .sa (sa),
    .sb (sb),
    .ne (s_ne),
    .lt (s_lt)
  );

  logic dec_now;     // this slice is the first one that differs
  logic decided_nx;  // decision state including this slice
  logic lt_nx;       // lt including this slice

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    f3_d       = f3_q;
    idx_d      = idx_q;
    decided_d  = decided_q;
    cmp_lt_d   = cmp_lt_q;
    eq_d       = eq_q;
    lt_d       = lt_q;
    taken_d    = taken_q;
    illegal_d  = illegal_q;

    dec_now    = ~decided_q & s_ne;
    decided_nx = decided_q | s_ne;
    lt_nx      = dec_now ? s_lt : cmp_lt_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_d       = bus.a;
            b_d       = bus.b;
            // Flipping the sign bits turns a signed compare into an
            // unsigned one; illegal encodings have funct3[1]=1 and stay unsigned.
            a_d[XLEN-1] = bus.a[XLEN-1] ^ ~bus.funct3[1];
            b_d[XLEN-1] = bus.b[XLEN-1] ^ ~bus.funct3[1];
            f3_d      = bus.funct3;
            idx_d     = IDXW'(NSLICE - 1);
            decided_d = 1'b0;
            cmp_lt_d  = 1'b0;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          decided_d = decided_nx;
          cmp_lt_d  = lt_nx;
          if ((idx_q == '0) || (EARLY_EXIT && dec_now)) begin
            state_d   = DONE;
            eq_d      = ~decided_nx;
            lt_d      = decided_nx & lt_nx;
            taken_d   = branch_taken(f3_q, ~decided_nx, decided_nx & lt_nx);
            illegal_d = f3_illegal(f3_q);
          end else begin
            idx_d = idx_q - IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      f3_q      <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      cmp_lt_q  <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      f3_q      <= f3_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      cmp_lt_q  <= cmp_lt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

  // in_ready is held low while rst is asserted so nothing is offered
  // during the reset cycle itself.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.taken     = taken_q;
  assign bus.illegal   = illegal_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Directed bench for branch_cmp_seq. Three instances share clk/rst/flush and
// the operand inputs: u_dut0 (CHUNK=8, no early exit), u_dut1 (CHUNK=8,
// early exit) and u_dut2 (CHUNK=32). in_valid is steered to one instance
// at a time via sel, and that instance's outputs are observed.
module tb_branch_cmp_seq;
  import branch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  logic [2:0]  in_valid_v;
  logic [31:0] a_in, b_in;
  logic [2:0]  f3_in;
  logic        out_ready;
  int          sel;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] exp_q[$];  // expected {eq, lt, taken, illegal}

  branch_cmp_seq_if #(.XLEN(32)) bus0 ();
  branch_cmp_seq_if #(.XLEN(32)) bus1 ();
  branch_cmp_seq_if #(.XLEN(32)) bus2 ();
  state_e st0, st1, st2;

  assign bus0.in_valid = in_valid_v[0];
  assign bus1.in_valid = in_valid_v[1];
  assign bus2.in_valid = in_valid_v[2];
  assign bus0.a = a_in;  assign bus1.a = a_in;  assign bus2.a = a_in;
  assign bus0.b = b_in;  assign bus1.b = b_in;  assign bus2.b = b_in;
  assign bus0.funct3 = f3_in;  assign bus1.funct3 = f3_in;  assign bus2.funct3 = f3_in;
  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;
  assign bus2.out_ready = out_ready;

  branch_cmp_seq #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .state_o(st0));
  branch_cmp_seq #(.XLEN(32), .CHUNK(8), .EARLY_EXIT(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .state_o(st1));
  branch_cmp_seq #(.XLEN(32), .CHUNK(32), .EARLY_EXIT(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus2), .state_o(st2));

  logic       obs_in_ready, obs_out_valid;
  logic [3:0] obs_res;
  state_e     obs_state;

  always_comb begin
    obs_in_ready  = 1'b0;
    obs_out_valid = 1'b0;
    obs_res       = '0;
    obs_state     = IDLE;
    case (sel)
      0: begin
        obs_in_ready = bus0.in_ready; obs_out_valid = bus0.out_valid;
        obs_res = {bus0.eq, bus0.lt, bus0.taken, bus0.illegal}; obs_state = st0;
      end
      1: begin
        obs_in_ready = bus1.in_ready; obs_out_valid = bus1.out_valid;
        obs_res = {bus1.eq, bus1.lt, bus1.taken, bus1.illegal}; obs_state = st1;
      end
      default: begin
        obs_in_ready = bus2.in_ready; obs_out_valid = bus2.out_valid;
        obs_res = {bus2.eq, bus2.lt, bus2.taken, bus2.illegal}; obs_state = st2;
      end
    endcase
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {eq, lt, taken, illegal} from plain integer compares.
  function automatic logic [3:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3);
    logic eq, lt, tk, il;
    eq = (a == b);
    lt = f3[1] ? (a < b) : ($signed(a) < $signed(b));
    il = (f3 == 3'b010) || (f3 == 3'b011);
    case (f3)
      3'b000: tk = eq;
      3'b001: tk = !eq;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default: tk = 1'b0;
    endcase
    return {eq, lt, tk, il};
  endfunction

  // ---------------- driver ----------------
  // Issue one request to instance s, measure latency, check the result,
  // optionally hold out_ready low for `hold` cycles in DONE.
  task automatic run_req(input int s, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [3:0] exp_res,
                         input int exp_lat, input int hold);
    int lat;
    logic [3:0] exp_now;
    sel = s;
    exp_q.push_back(exp_res);
    @(negedge clk);
    a_in = a; b_in = b; f3_in = f3;
    out_ready = (hold == 0);
    in_valid_v = 3'b001 << s;
    check("in_ready", 32'(obs_in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid_v = '0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!obs_out_valid && lat < 40);
    check("latency", 32'(lat), 32'(exp_lat));
    exp_now = exp_q.pop_front();
    check("result", 32'(obs_res), 32'(exp_now));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_result", 32'(obs_res), 32'(exp_now));
      check("hold_valid", 32'(obs_out_valid), 32'd1);
      check("hold_in_ready", 32'(obs_in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("ret_valid", 32'(obs_out_valid), 32'd0);
    check("ret_in_ready", 32'(obs_in_ready), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3_tab [8];
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    logic        seen;
    f3_tab = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};

    rst = 1'b1; flush = 1'b0; in_valid_v = '0; out_ready = 1'b0;
    a_in = '0; b_in = '0; f3_in = '0; sel = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cycle_in_ready", 32'(obs_in_ready), 32'd0);
    check("rst_state", 32'(obs_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(obs_in_ready), 32'd1);
    check("post_rst_out_valid", 32'(obs_out_valid), 32'd0);
    check("post_rst_outputs", 32'(obs_res), 32'd0);

    // EARLY_EXIT=0, fixed NSLICE latency
    run_req(0, 32'hFFFF_FFFF, 32'h0000_0001, F3_BLT,  4'b0110, 4, 0);
    run_req(0, 32'hFFFF_FFFF, 32'h0000_0001, F3_BLTU, 4'b0000, 4, 0);
    run_req(0, 32'h0000_0005, 32'h0000_0005, F3_BNE,  4'b1000, 4, 0);

    // EARLY_EXIT=1
    run_req(1, 32'h1200_0000, 32'h1300_0000, F3_BGE,  4'b0100, 1, 0);
    run_req(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, F3_BEQ,  4'b1010, 4, 0);
    run_req(1, 32'h0000_0003, 32'h0000_0005, 3'b010,  4'b0101, 4, 0);
    run_req(1, 32'h0001_0000, 32'h0000_FFFF, F3_BGEU, 4'b0010, 2, 0);
    run_req(1, 32'h8000_0000, 32'h0000_0001, 3'b011,  4'b0001, 1, 0);
    run_req(1, 32'h8000_0000, 32'h7FFF_FFFF, F3_BLT,  4'b0110, 1, 0);

    // Back-pressure: 5 cycles with out_ready low in DONE
    run_req(0, 32'h0000_0010, 32'h0000_0020, F3_BGE,  4'b0100, 4, 5);

    // Flush in the 2nd BUSY cycle
    sel = 0;
    @(negedge clk);
    a_in = 32'h1; b_in = 32'h2; f3_in = F3_BLTU; out_ready = 1'b1; in_valid_v = 3'b001;
    @(posedge clk);
    #1 in_valid_v = '0;
    @(negedge clk);
    check("flush_busy1", 32'(obs_state), 32'(BUSY));
    @(negedge clk);
    check("flush_busy2", 32'(obs_state), 32'(BUSY));
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_idle", 32'(obs_state), 32'(IDLE));
    seen = obs_out_valid;
    repeat (6) begin
      @(negedge clk);
      if (obs_out_valid) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);
    // A request together with flush is not accepted
    @(negedge clk);
    in_valid_v = 3'b001; flush = 1'b1;
    @(posedge clk);
    #1 begin in_valid_v = '0; flush = 1'b0; end
    @(negedge clk);
    check("flush_reject", 32'(obs_state), 32'(IDLE));
    run_req(0, 32'h0000_0001, 32'h0000_0002, F3_BLTU, 4'b0110, 4, 0);

    // Reset in BUSY on u_dut1 (its outputs hold a nonzero result here)
    run_req(1, 32'h8000_0000, 32'h7FFF_FFFF, F3_BLT, 4'b0110, 1, 0);
    sel = 1;
    @(negedge clk);
    a_in = 32'hDEAD_BEEF; b_in = 32'hDEAD_BEEF; f3_in = F3_BEQ; in_valid_v = 3'b010;
    @(posedge clk);
    #1 in_valid_v = '0;
    @(negedge clk);
    check("rst_busy_state", 32'(obs_state), 32'(BUSY));
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy_in_ready", 32'(obs_in_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy_outputs", 32'(obs_res), 32'd0);
    check("rst_busy_out_valid", 32'(obs_out_valid), 32'd0);
    check("rst_busy_in_ready_after", 32'(obs_in_ready), 32'd1);

    // CHUNK=32: random signed/unsigned pairs, latency 1 always
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (32'h1 << $urandom_range(0, 31));
        2: rb = 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      rf = f3_tab[$urandom_range(0, 7)];
      run_req(2, ra, rb, rf, ref_model(ra, rb, rf), 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
